rom_loader: RTL

Instruction-memory responder for the CPU's fetch port. It receives a program as a byte stream, for example from a UART receiver, and assembles little-endian 32-bit words into internal word memory. While the stream arrives it holds the CPU in reset with its clock gated off; once the stream completes it releases the CPU. It then answers the CPU's `rom_address` requests with `rom_data`.

---
 rtl/rom_loader_if.sv | 24 ++
 rtl/rom_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_loader_if.sv
// Byte-stream input and instruction-fetch bus shared between the ROM loader
// and whatever feeds it (UART receiver on one side, CPU fetch on the other).
interface rom_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] rom_address;
  logic [31:0] rom_data;

  // Driver side: supplies program bytes and fetch addresses, consumes words
  modport master (
    output rx_data,
    output rx_valid,
    output rom_address,
    input  rom_data
  );

  // Loader side: consumes bytes and addresses, answers with instruction words
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rom_address,
    output rom_data
  );
endinterface

// File: rtl/rom_loader.sv
// Instruction ROM loader: receives a length-prefixed little-endian byte stream,
// stores it as 32-bit words, holds the CPU in reset while loading, then serves
// combinational instruction fetches. Memory contents survive reset; only the
// control state, counters and flags are cleared.
module rom_loader #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic         clock,
  input  logic         reset,
  rom_loader_if.slave  bus,
  output logic         cpu_reset,
  output logic         cpu_enable,
  output logic [15:0]  loaded_words,
  output logic         overflow
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    LOAD,
    RELEASE,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  // Holds the first three bytes of a word; the fourth byte is taken straight
  // from rx_data so the word can be written on the edge that samples it.
  logic [23:0] asm_q, asm_d;
  logic [15:0] loadedWords_q, loadedWords_d;
  logic        overflow_q, overflow_d;

  logic              memWe;
  logic [ADDR_W-1:0] memIdx;
  logic [31:0]       memWord;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] rdIdx;
  logic              rdHighZero;
  logic              unusedAddrBits;

  // Control registers: cleared asynchronously, so a mid-load reset drops any partial word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= LEN_LO;
      len_q         <= '0;
      byteCnt_q     <= '0;
      asm_q         <= '0;
      loadedWords_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byteCnt_q     <= byteCnt_d;
      asm_q         <= asm_d;
      loadedWords_q <= loadedWords_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state logic: length header, word assembly, then one release cycle before run
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    byteCnt_d     = byteCnt_q;
    asm_d         = asm_q;
    loadedWords_d = loadedWords_q;
    overflow_d    = overflow_q;
    memWe         = 1'b0;
    memIdx        = loadedWords_q[ADDR_W-1:0];
    memWord       = {bus.rx_data, asm_q};

    case (state_q)
      LEN_LO: begin
        if (bus.rx_valid) begin
          len_d   = {8'h00, bus.rx_data};
          state_d = LEN_HI;
        end
      end

      LEN_HI: begin
        if (bus.rx_valid) begin
          len_d = {bus.rx_data, len_q[7:0]};
          if (len_d == 16'd0) begin
            state_d = RELEASE;
          end else begin
            state_d = LOAD;
          end
          if ({1'b0, len_d} > 17'(DEPTH)) begin
            overflow_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (bus.rx_valid) begin
          asm_d     = {bus.rx_data, asm_q[23:8]};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            // Words past the end of memory are still counted so the stream
            // length bookkeeping stays correct; they just never get stored.
            memWe = (32'(loadedWords_q) < 32'(DEPTH));
            if (loadedWords_q != 16'hFFFF) begin
              loadedWords_d = loadedWords_q + 16'd1;
            end
            if ((17'(loadedWords_q) + 17'd1) == 17'(len_q)) begin
              state_d = RELEASE;
            end
          end
        end
      end

      RELEASE: begin
        state_d = RUN;
      end

      RUN: begin
        state_d = RUN;
      end

      default: begin
        state_d = LEN_LO;
      end
    endcase
  end

  // Word memory: deliberately has no reset so it keeps its contents across resets
  always_ff @(posedge clock) begin
    if (memWe) begin
      mem[memIdx] <= memWord;
    end
  end

  // CPU control: reset drops on entering RELEASE, clock enable follows one cycle later
  always_comb begin
    cpu_reset  = 1'b1;
    cpu_enable = 1'b0;
    case (state_q)
      RELEASE: begin
        cpu_reset = 1'b0;
      end
      RUN: begin
        cpu_reset  = 1'b0;
        cpu_enable = 1'b1;
      end
      default: begin
        cpu_reset  = 1'b1;
        cpu_enable = 1'b0;
      end
    endcase
  end

  assign rdIdx          = bus.rom_address[ADDR_W+1:2];
  assign rdHighZero     = (bus.rom_address[31:ADDR_W+2] == '0);
  assign unusedAddrBits = ^bus.rom_address[1:0];

  // Fetch path: only words already loaded are visible, everything else reads as a NOP
  always_comb begin
    bus.rom_data = NOP_WORD;
    if (rdHighZero && (32'(rdIdx) < 32'(loadedWords_q))) begin
      bus.rom_data = mem[rdIdx];
    end
  end

  assign loaded_words = loadedWords_q;
  assign overflow     = overflow_q;

endmodule
